// File: rtl/gauss_sa_driver.sv
// Host-side driver for the GF(2) Gaussian-elimination systolic array.
// Buffers a host-written matrix, streams it one row per cycle into the array, and captures the de-skewed result.
module gauss_sa_driver #(
  parameter int DAT_W   = 4,
  parameter int N_ROWS  = 4,
  parameter int RES_DLY = 0,
  parameter int TIMEOUT = 64,
  localparam int AW     = $clog2(N_ROWS),
  localparam int PW     = $clog2(N_ROWS + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             wr_en,
  input  logic [DAT_W-1:0] wr_data,
  input  logic             wr_swap,
  input  logic             go,
  input  logic             go_mode,
  output logic             sa_start,
  output logic             sa_swap,
  output logic             sa_mode,
  output logic [DAT_W-1:0] sa_data,
  input  logic             sa_finish,
  input  logic             sa_full_rank,
  input  logic [DAT_W-1:0] sa_result,
  output logic             busy,
  output logic             done,
  output logic             full_rank_q,
  output logic             err_go,
  output logic             err_timeout,
  input  logic [AW-1:0]    rd_addr,
  output logic [DAT_W-1:0] rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_WAIT,
    S_COLLECT
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [DAT_W:0]   row_q [N_ROWS];
  logic [DAT_W:0]   row_d [N_ROWS];
  logic [DAT_W-1:0] res_q [N_ROWS];
  logic [DAT_W-1:0] res_d [N_ROWS];
  logic             sa_start_q, sa_start_d;
  logic             sa_swap_q, sa_swap_d;
  logic             sa_mode_q, sa_mode_d;
  logic [DAT_W-1:0] sa_data_q, sa_data_d;
  logic             done_q, done_d;
  logic             full_rank_d;
  logic             err_go_q, err_go_d;
  logic             err_timeout_q, err_timeout_d;
  logic             go_ok;
  logic [7:0]       slot;

  // go is judged against the pre-write pointer, so a same-cycle write cannot make it acceptable.
  assign go_ok = (state_q == S_LOAD) && (wr_ptr_q == PW'(N_ROWS));
  // Result slot index; wraps to a large value while skipping the first RES_DLY cycles.
  assign slot  = cnt_q - 8'(RES_DLY);

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;
    row_d         = row_q;
    res_d         = res_q;
    sa_start_d    = 1'b0;
    sa_swap_d     = 1'b0;
    sa_data_d     = '0;
    sa_mode_d     = sa_mode_q;
    done_d        = done_q;
    full_rank_d   = full_rank_q;
    err_go_d      = go && !go_ok;
    err_timeout_d = err_timeout_q;

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (wr_en) begin
          done_d = 1'b0;
          if (wr_ptr_q < PW'(N_ROWS)) begin
            row_d[wr_ptr_q[AW-1:0]] = {wr_swap, wr_data};
            wr_ptr_d                = wr_ptr_q + PW'(1);
            state_d                 = S_LOAD;
          end
        end
        if (go && go_ok) begin
          sa_mode_d     = go_mode;
          err_timeout_d = 1'b0;
          done_d        = 1'b0;
          cnt_d         = '0;
          state_d       = S_FEED;
        end
      end

      S_FEED: begin
        sa_data_d  = row_q[cnt_q[AW-1:0]][DAT_W-1:0];
        sa_swap_d  = row_q[cnt_q[AW-1:0]][DAT_W];
        sa_start_d = (cnt_q == 8'd0);
        if (cnt_q == 8'(N_ROWS - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_WAIT: begin
        if (sa_finish) begin
          full_rank_d = sa_full_rank;
          cnt_d       = '0;
          state_d     = S_COLLECT;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          wr_ptr_d      = '0;
          done_d        = 1'b0;
          cnt_d         = '0;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_COLLECT: begin
        if (slot < 8'(N_ROWS)) begin
          res_d[slot[AW-1:0]] = sa_result;
        end
        if (slot == 8'(N_ROWS - 1)) begin
          done_d   = 1'b1;
          wr_ptr_d = '0;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      for (int i = 0; i < N_ROWS; i++) begin
        row_q[i] <= '0;
        res_q[i] <= '0;
      end
      sa_start_q    <= 1'b0;
      sa_swap_q     <= 1'b0;
      sa_mode_q     <= 1'b0;
      sa_data_q     <= '0;
      done_q        <= 1'b0;
      full_rank_q   <= 1'b0;
      err_go_q      <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      res_q         <= res_d;
      sa_start_q    <= sa_start_d;
      sa_swap_q     <= sa_swap_d;
      sa_mode_q     <= sa_mode_d;
      sa_data_q     <= sa_data_d;
      done_q        <= done_d;
      full_rank_q   <= full_rank_d;
      err_go_q      <= err_go_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign sa_start    = sa_start_q;
  assign sa_swap     = sa_swap_q;
  assign sa_mode     = sa_mode_q;
  assign sa_data     = sa_data_q;
  assign busy        = (state_q == S_FEED) || (state_q == S_WAIT) || (state_q == S_COLLECT);
  assign done        = done_q;
  assign err_go      = err_go_q;
  assign err_timeout = err_timeout_q;
  assign rd_data     = res_q[rd_addr];

endmodule

// File: tb/tb_gauss_sa_driver.sv
// Directed bench for gauss_sa_driver: feed timing, result capture with a 2-cycle skip, go rejection, timeout, reset.
module tb_gauss_sa_driver;

  localparam int DAT_W   = 4;
  localparam int N_ROWS  = 4;
  localparam int RES_DLY = 2;
  localparam int TIMEOUT = 64;

  logic             clk;
  logic             rst_b;
  logic             wr_en;
  logic [DAT_W-1:0] wr_data;
  logic             wr_swap;
  logic             go;
  logic             go_mode;
  logic             sa_start;
  logic             sa_swap;
  logic             sa_mode;
  logic [DAT_W-1:0] sa_data;
  logic             sa_finish;
  logic             sa_full_rank;
  logic [DAT_W-1:0] sa_result;
  logic             busy;
  logic             done;
  logic             full_rank_q;
  logic             err_go;
  logic             err_timeout;
  logic [1:0]       rd_addr;
  logic [DAT_W-1:0] rd_data;

  logic [DAT_W-1:0] row_v [N_ROWS];
  logic             swap_v [N_ROWS];
  logic [DAT_W-1:0] res_v [N_ROWS];
  logic             cur_mode;

  int n_chk;
  int n_pass;

  gauss_sa_driver #(
    .DAT_W  (DAT_W),
    .N_ROWS (N_ROWS),
    .RES_DLY(RES_DLY),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_swap     (wr_swap),
    .go          (go),
    .go_mode     (go_mode),
    .sa_start    (sa_start),
    .sa_swap     (sa_swap),
    .sa_mode     (sa_mode),
    .sa_data     (sa_data),
    .sa_finish   (sa_finish),
    .sa_full_rank(sa_full_rank),
    .sa_result   (sa_result),
    .busy        (busy),
    .done        (done),
    .full_rank_q (full_rank_q),
    .err_go      (err_go),
    .err_timeout (err_timeout),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [DAT_W-1:0] d, input logic s);
    wr_en   = 1'b1;
    wr_data = d;
    wr_swap = s;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < N_ROWS; i++) wr(row_v[i], swap_v[i]);
  endtask

  // Pulses an accepted go and checks every feed beat plus the idle beat after it.
  task automatic go_feed(input logic m);
    cur_mode = m;
    go       = 1'b1;
    go_mode  = m;
    step();
    go       = 1'b0;
    go_mode  = 1'b0;
    check("busy_after_go", busy, 1);
    check("done_after_go", done, 0);
    check("start_before_beat0", sa_start, 0);
    check("mode_first_feed", sa_mode, m);
    for (int k = 0; k < N_ROWS; k++) begin
      step();
      check($sformatf("beat%0d_data", k), sa_data, row_v[k]);
      check($sformatf("beat%0d_swap", k), sa_swap, swap_v[k]);
      check($sformatf("beat%0d_start", k), sa_start, (k == 0) ? 1 : 0);
      check($sformatf("beat%0d_mode", k), sa_mode, m);
    end
    step();
    check("data_after_feed", sa_data, 0);
    check("start_after_feed", sa_start, 0);
    check("swap_after_feed", sa_swap, 0);
  endtask

  // Array model: finish some cycles after the last beat, garbage during the skip, then the result rows.
  task automatic respond(input logic fr);
    repeat (5) step();
    sa_finish    = 1'b1;
    sa_full_rank = fr;
    sa_result    = 4'hF;
    step();
    sa_finish    = 1'b0;
    sa_full_rank = ~fr;
    check("busy_collect", busy, 1);
    check("full_rank_captured", full_rank_q, fr);
    for (int d = 0; d < RES_DLY; d++) step();
    for (int j = 0; j < N_ROWS; j++) begin
      check($sformatf("busy_before_row%0d", j), busy, 1);
      sa_result = res_v[j];
      step();
    end
    sa_result    = '0;
    sa_full_rank = 1'b0;
    check("busy_end", busy, 0);
    check("done_end", done, 1);
    check("full_rank_end", full_rank_q, fr);
    check("mode_held", sa_mode, cur_mode);
    for (int j = 0; j < N_ROWS; j++) begin
      rd_addr = 2'(j);
      #1;
      check($sformatf("rd_row%0d", j), rd_data, res_v[j]);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_full_rank"}, full_rank_q, 0);
    check({tag, "_err_go"}, err_go, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
    check({tag, "_sa_start"}, sa_start, 0);
    check({tag, "_sa_swap"}, sa_swap, 0);
    check({tag, "_sa_mode"}, sa_mode, 0);
    check({tag, "_sa_data"}, sa_data, 0);
    for (int j = 0; j < N_ROWS; j++) begin
      rd_addr = 2'(j);
      #1;
      check($sformatf("%s_rd%0d", tag, j), rd_data, 0);
    end
  endtask

  initial begin
    n_chk        = 0;
    n_pass       = 0;
    rst_b        = 1'b0;
    wr_en        = 1'b0;
    wr_data      = '0;
    wr_swap      = 1'b0;
    go           = 1'b0;
    go_mode      = 1'b0;
    sa_finish    = 1'b0;
    sa_full_rank = 1'b0;
    sa_result    = '0;
    rd_addr      = '0;
    cur_mode     = 1'b0;
    repeat (2) step();
    check_zero_outputs("reset");
    rst_b = 1'b1;
    step();

    // Identity matrix, full rank
    row_v  = '{4'h8, 4'h4, 4'h2, 4'h1};
    swap_v = '{1'b0, 1'b0, 1'b0, 1'b0};
    res_v  = '{4'h8, 4'h4, 4'h2, 4'h1};
    load_all();
    go_feed(1'b0);
    respond(1'b1);

    // Rank-deficient matrix; the first write must clear done
    row_v  = '{4'hC, 4'hC, 4'h3, 4'h3};
    res_v  = '{4'hC, 4'h3, 4'h0, 4'h0};
    wr(row_v[0], swap_v[0]);
    check("done_cleared_by_write", done, 0);
    for (int i = 1; i < N_ROWS; i++) wr(row_v[i], swap_v[i]);
    go_feed(1'b0);
    respond(1'b0);

    // Swap bits and mode 1
    row_v  = '{4'hA, 4'h5, 4'h6, 4'h9};
    swap_v = '{1'b1, 1'b0, 1'b1, 1'b0};
    res_v  = '{4'h9, 4'h6, 4'h5, 4'hA};
    load_all();
    go_feed(1'b1);
    respond(1'b1);

    // Rejected go: in IDLE, after 3 writes, with a same-cycle 4th write, and while busy
    go = 1'b1;
    step();
    go = 1'b0;
    check("err_go_idle", err_go, 1);
    check("busy_idle_go", busy, 0);
    step();
    check("err_go_one_cycle", err_go, 0);
    row_v  = '{4'h1, 4'h2, 4'h4, 4'h7};
    swap_v = '{1'b0, 1'b1, 1'b1, 1'b0};
    res_v  = '{4'h7, 4'h4, 4'h2, 4'h1};
    for (int i = 0; i < 3; i++) wr(row_v[i], swap_v[i]);
    go = 1'b1;
    step();
    go = 1'b0;
    check("err_go_three_rows", err_go, 1);
    check("busy_three_rows", busy, 0);
    go = 1'b1;
    wr(row_v[3], swap_v[3]);
    go = 1'b0;
    check("err_go_with_write", err_go, 1);
    check("busy_with_write", busy, 0);
    wr(4'hE, 1'b1);
    check("err_go_clear", err_go, 0);
    go_feed(1'b0);
    go = 1'b1;
    step();
    go = 1'b0;
    check("err_go_busy", err_go, 1);
    check("busy_kept", busy, 1);
    respond(1'b1);

    // Timeout: WAIT entered at the edge driving beat 3, err_timeout 64 edges later
    row_v  = '{4'h3, 4'h5, 4'h9, 4'h6};
    swap_v = '{1'b0, 1'b0, 1'b1, 1'b1};
    load_all();
    go_feed(1'b1);
    repeat (TIMEOUT - 2) step();
    check("timeout_not_yet", err_timeout, 0);
    check("busy_before_timeout", busy, 1);
    step();
    check("timeout_set", err_timeout, 1);
    check("busy_after_timeout", busy, 0);
    check("done_after_timeout", done, 0);
    step();
    check("timeout_sticky", err_timeout, 1);
    res_v = '{4'h6, 4'h5, 4'h3, 4'h9};
    load_all();
    check("timeout_kept_by_writes", err_timeout, 1);
    go_feed(1'b0);
    check("timeout_cleared_by_go", err_timeout, 0);
    respond(1'b0);

    // Reset during COLLECT, then a clean run
    row_v  = '{4'hB, 4'hD, 4'h1, 4'h8};
    swap_v = '{1'b1, 1'b1, 1'b0, 1'b1};
    res_v  = '{4'h2, 4'hB, 4'hD, 4'h4};
    load_all();
    go_feed(1'b1);
    repeat (3) step();
    sa_finish    = 1'b1;
    sa_full_rank = 1'b1;
    step();
    sa_finish    = 1'b0;
    sa_full_rank = 1'b0;
    step();
    check("pre_reset_busy", busy, 1);
    check("pre_reset_full_rank", full_rank_q, 1);
    rst_b = 1'b0;
    #1;
    check_zero_outputs("midrun_reset");
    #1;
    rst_b = 1'b1;
    step();
    load_all();
    go_feed(1'b1);
    respond(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/gauss_sa_driver.md
# gauss_sa_driver

Host-side driver for the GF(2) Gaussian-elimination systolic array. It buffers an N_ROWS x DAT_W binary matrix written by the host and streams it row-per-cycle into the array's `start`/`swap`/`mode`/`data` inputs. It then captures the array's `finish`, `full_rank` and de-skewed `result` outputs into a readable result buffer. It sits between the control bus and the array, and is the array's only producer and consumer.

## Interface
- DAT_W, 4, row width in bits; equals the array's DAT_W.
- N_ROWS, 4, rows per matrix, 2..16.
- RES_DLY, 0, cycles from sampled `sa_finish` to the first valid `sa_result` beat, 0..7.
- TIMEOUT, 64, maximum cycles in WAIT before `err_timeout`, at most 255.
- clk  in  1  single system clock, rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- wr_en  in  1  host row write strobe.
- wr_data  in  DAT_W  row value; MSB = column 0.
- wr_swap  in  1  per-row swap bit stored with the row.
- go  in  1  single-cycle pulse that starts a run.
- go_mode  in  1  array mode for the run; latched on accepted `go`.
- sa_start  out  1  array start pulse.
- sa_swap  out  1  array swap input.
- sa_mode  out  1  array mode input.
- sa_data  out  DAT_W  array row input.
- sa_finish  in  1  array finish flag.
- sa_full_rank  in  1  array rank flag.
- sa_result  in  DAT_W  array de-skewed result row.
- busy  out  1  high in FEED, WAIT and COLLECT.
- done  out  1  high from end of COLLECT until the next accepted `go` or a write.
- full_rank_q  out  1  `sa_full_rank` captured at the sampled `sa_finish`.
- err_go  out  1  one-cycle pulse: `go` rejected.
- err_timeout  out  1  sticky; cleared by accepted `go`.
- rd_addr  in  log2(N_ROWS)  result row select.
- rd_data  out  DAT_W  result row; combinational from the buffer.

## Operation
- States: IDLE, LOAD, FEED, WAIT, COLLECT.
- IDLE / LOAD:
  - `wr_en` writes `{wr_swap, wr_data}` at `wr_ptr`, then increments `wr_ptr`. IDLE moves to LOAD on the first write.
  - Writes with `wr_ptr == N_ROWS` are dropped; no wrap.
  - A write clears `done`.
  - `wr_en` in FEED, WAIT or COLLECT is ignored.
- `go` acceptance:
  - Accepted only in LOAD with `wr_ptr == N_ROWS`. Latches `go_mode`, clears `err_timeout` and `done`, then enters FEED.
  - Otherwise `go` raises `err_go` for one cycle, including `go` while busy.
  - `go` together with `wr_en` in the same cycle: the write takes priority and `go` is evaluated against the pre-write `wr_ptr`.
- FEED: beats k = 0..N_ROWS-1 on consecutive cycles.
  - `sa_data` = row k.
  - `sa_swap` = swap bit of row k.
  - `sa_start` = 1 only on beat 0.
  - `sa_mode` = latched mode, held from the first FEED cycle until the next accepted `go`.
  - After beat N_ROWS-1, go to WAIT.
  - Outside FEED, `sa_data`, `sa_swap` and `sa_start` are 0.
- WAIT:
  - Cycle counter runs from 0.
  - `sa_finish` sampled high: capture `full_rank_q`, then enter COLLECT.
  - Counter reaches TIMEOUT without `sa_finish`: set `err_timeout`, `wr_ptr` = 0, enter IDLE with `done` = 0.
- COLLECT:
  - Skip RES_DLY cycles, then store `sa_result` into result row j on N_ROWS consecutive cycles, j = 0..N_ROWS-1.
  - After the last store: `done` = 1, `wr_ptr` = 0, enter IDLE.
- `sa_finish` outside WAIT is ignored.
- Input rows are retained after a run. The host must rewrite all N_ROWS rows before the next `go`.
- Reset (`rst_b` low, any time including mid-run):
  - State IDLE; `wr_ptr`, all counters and the result buffer cleared to 0.
  - Outputs: `busy` = 0, `done` = 0, `full_rank_q` = 0, `err_go` = 0, `err_timeout` = 0, `sa_start` = 0, `sa_swap` = 0, `sa_mode` = 0, `sa_data` = 0.
  - A run interrupted by reset is discarded.

## Timing
- All `sa_*` outputs are registered.
- Accepted `go` at edge t: beat 0 drives `sa_*` after edge t+1, and beat k after edge t+1+k.
- `busy` rises after edge t and falls after the edge that writes the last result row.
- `done` rises on the same edge `busy` falls.
- `sa_finish` sampled at edge f: result row 0 is written at edge f+1+RES_DLY and row j at edge f+1+RES_DLY+j.
- `rd_data` reflects a write on the next cycle.
- `err_go` is asserted in the cycle after the rejected `go`.

## Test plan
- DAT_W=4, N_ROWS=4:
  - Stimulus: write rows 1000, 0100, 0010, 0001 with swap 0; `go` with mode 0; model `sa_finish` 6 cycles after the last beat with `sa_full_rank` = 1 and results 1000..0001.
  - Required: `sa_start` high on beat 0 only, beats on 4 consecutive cycles, `done` = 1, `full_rank_q` = 1, `rd_data[0..3]` = 8,4,2,1.
- Rank-deficient run:
  - Stimulus: rows 1100, 1100, 0011, 0011 with `sa_full_rank` = 0.
  - Required: `full_rank_q` = 0; results captured exactly as driven.
- Swap bits and mode:
  - Stimulus: swap bits 1,0,1,0; `go_mode` = 1.
  - Required: `sa_swap` = 1,0,1,0 on beats 0..3; `sa_mode` = 1 throughout the run.
- Rejected `go`:
  - Stimulus: `go` after 3 writes; then `go` while busy; then a 5th write with `wr_ptr` = 4.
  - Required: `err_go` pulses on each rejected `go`; state unchanged; 5th write dropped, row 3 unchanged.
- Timeout:
  - Stimulus: never assert `sa_finish`.
  - Required: `err_timeout` = 1 exactly 64 cycles after WAIT entry; state IDLE; `busy` = 0; the next accepted `go` clears `err_timeout`.
- Reset mid-run, with RES_DLY=2:
  - Stimulus: drop `rst_b` during COLLECT.
  - Required: all outputs and `rd_data` = 0 immediately; a new full run succeeds with 2-cycle result skip alignment.
